// File: rtl/wb_bus_arbiter_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM states, grant
// vectors and the default stall timeout.
package wb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/wb_bus_arbiter_rr_pick.sv
// Combinational two-way round-robin chooser: on a tie the master that did
// not own the bus last wins.
module wb_arb_rr_pick
  import wb_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] pick
);

  always_comb begin
    pick = GNT_NONE;
    case (req)
      2'b01:   pick = GNT_M0;
      2'b10:   pick = GNT_M1;
      2'b11:   pick = last_owner ? GNT_M0 : GNT_M1;
      default: pick = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter, round-robin, grant held for a whole
// cyc burst. Define WB_ARB_TIMEOUT_EN to enable the stalled-slave timeout.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  input  logic              m0_we_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  input  logic              m1_we_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o
);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] pick;
  logic       timeout_hit;

  wb_arb_rr_pick u_pick (
    .req        ({m1_cyc_i, m0_cyc_i}),
    .last_owner (last_owner_q),
    .pick       (pick)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (pick == GNT_M0)      state_d = ST_OWN0;
        else if (pick == GNT_M1) state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (timeout_hit || !m0_cyc_i) begin
          state_d      = (m1_cyc_i && !timeout_hit) ? ST_OWN1 : ST_IDLE;
          last_owner_d = 1'b0;
        end
      end
      ST_OWN1: begin
        if (timeout_hit || !m1_cyc_i) begin
          state_d      = (m0_cyc_i && !timeout_hit) ? ST_OWN0 : ST_IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_OWN0: grant_d = GNT_M0;
      ST_OWN1: grant_d = GNT_M1;
      default: grant_d = GNT_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      grant_q      <= GNT_NONE;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
    end
  end

  assign grant_o  = grant_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Ack is qualified by the owner's cyc so a late ack after cyc drops is lost.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      ST_OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i & m0_cyc_i;
        m0_err_o = timeout_hit;
      end
      ST_OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i & m1_cyc_i;
        m1_err_o = timeout_hit;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    timeout_hit = s_stb_o && !s_ack_i && (to_cnt_q == TO_LAST);
    to_cnt_d    = to_cnt_q;
    if (s_ack_i || (state_d != state_q)) to_cnt_d = '0;
    else if (s_stb_o)                    to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed self-checking bench for wb_bus_arbiter with a small latency-2
// behavioural memory slave.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
  logic        m0_we_i = 1'b0, m0_cyc_i = 1'b0, m0_stb_i = 1'b0;
  logic        m1_we_i = 1'b0, m1_cyc_i = 1'b0, m1_stb_i = 1'b0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  // Memory slave: acks 2 cycles after stb, writes land in mem, reads return rd_word.
  localparam int unsigned SL_LAT = 2;
  logic [31:0] mem [0:255];
  logic [31:0] rd_word = 32'hDEAD_BEEF;
  logic        sl_noack = 1'b0;
  int unsigned sl_wait;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack_i <= 1'b0;
      s_dat_i <= '0;
      sl_wait <= 0;
    end else if (s_ack_i) begin
      s_ack_i <= 1'b0;
      sl_wait <= 0;
    end else if (s_cyc_o && s_stb_o && !sl_noack) begin
      if (sl_wait + 1 >= SL_LAT) begin
        s_ack_i <= 1'b1;
        sl_wait <= 0;
        if (s_we_o) mem[s_adr_o[9:2]] <= s_dat_o;
        else        s_dat_i <= rd_word;
      end else begin
        sl_wait <= sl_wait + 1;
      end
    end else begin
      sl_wait <= 0;
    end
  end

  int ack_log[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_ack_o) ack_log.push_back(0);
      if (m1_ack_o) ack_log.push_back(1);
    end
  end

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  task automatic wait_ack(input int m, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack_o) || (m == 1 && m1_ack_o)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic burst(input int m, input int n, input logic we,
                       input logic [31:0] adr0, input logic [31:0] dat0);
    bit ok;
    drive_m(m, 1'b1, 1'b1, we, adr0, dat0);
    for (int i = 0; i < n; i++) begin
      wait_ack(m, 100, ok);
      checks++;
      if (!ok) begin
        $display("FAIL burst_ack m%0d beat %0d: ack=0 after 100 cycles, required 1", m, i);
        errors++;
      end
      @(posedge clk); #1;
      if (i == n - 1) drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0);
      else drive_m(m, 1'b1, 1'b1, we, adr0 + 32'(4 * (i + 1)), dat0 + 32'(i + 1));
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sl_noack = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0123, 32'h5555_AAAA);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (grant_o !== 2'b00) begin $display("FAIL reset_grant: got %b expected 00", grant_o); errors++; end
    checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin $display("FAIL reset_ctl: got %b expected 000", {s_cyc_o, s_stb_o, s_we_o}); errors++; end
    checks++; if (s_adr_o !== 32'h0) begin $display("FAIL reset_adr: got %h expected 00000000", s_adr_o); errors++; end
    checks++; if (s_dat_o !== 32'h0) begin $display("FAIL reset_dat: got %h expected 00000000", s_dat_o); errors++; end
    checks++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin $display("FAIL reset_ack_err: got %b expected 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); errors++; end
    do_reset();
  endtask

  task automatic test_single_read;
    bit ok;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, '0);
    @(negedge clk);
    checks++; if (grant_o !== 2'b00) begin $display("FAIL t1_pre_grant: got %b expected 00", grant_o); errors++; end
    @(negedge clk);
    checks++; if (grant_o !== 2'b01) begin $display("FAIL t1_grant: got %b expected 01", grant_o); errors++; end
    checks++; if (s_adr_o !== 32'h10 || s_cyc_o !== 1'b1) begin $display("FAIL t1_route: got adr %h cyc %b expected 00000010 1", s_adr_o, s_cyc_o); errors++; end
    wait_ack(0, 20, ok);
    checks++; if (!ok) begin $display("FAIL t1_ack: got no ack expected ack"); errors++; end
    checks++; if (m0_dat_o !== 32'hDEAD_BEEF) begin $display("FAIL t1_rdata: got %h expected deadbeef", m0_dat_o); errors++; end
    checks++; if (m1_ack_o !== 1'b0) begin $display("FAIL t1_m1_ack: got %b expected 0", m1_ack_o); errors++; end
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    checks++; if (grant_o !== 2'b00) begin $display("FAIL t1_release: got %b expected 00", grant_o); errors++; end
  endtask

  task automatic test_tie;
    bit ok;
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, '0);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, '0);
    repeat (2) @(negedge clk);
    checks++; if (grant_o !== 2'b01) begin $display("FAIL t2_tie_grant: got %b expected 01", grant_o); errors++; end
    wait_ack(0, 20, ok);
    checks++; if (!ok || m1_ack_o !== 1'b0) begin $display("FAIL t2_m0_ack: got ok %b m1_ack %b expected 1 0", ok, m1_ack_o); errors++; end
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (grant_o !== 2'b01) begin $display("FAIL t2_hold: got %b expected 01", grant_o); errors++; end
    @(negedge clk);
    checks++; if (grant_o !== 2'b10) begin $display("FAIL t2_handover: got %b expected 10", grant_o); errors++; end
    wait_ack(1, 20, ok);
    checks++; if (!ok) begin $display("FAIL t2_m1_ack: got no ack expected ack"); errors++; end
    @(posedge clk); #1;
    drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_fairness;
    int base;
    do_reset();
    base = ack_log.size();
    fork
      begin
        repeat (3) begin burst(0, 1, 1'b0, 32'h0000_0080, '0); @(posedge clk); #1; end
      end
      begin
        repeat (3) begin burst(1, 1, 1'b0, 32'h0000_0090, '0); @(posedge clk); #1; end
      end
    join
    checks++;
    if (ack_log.size() != base + 6) begin
      $display("FAIL t3_count: got %0d acks expected 6", ack_log.size() - base); errors++;
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (ack_log[base + i] != i % 2) begin
          $display("FAIL t3_order[%0d]: got m%0d expected m%0d", i, ack_log[base + i], i % 2); errors++;
        end
      end
    end
  endtask

  task automatic test_burst_hold;
    bit ok;
    bit m1_done;
    do_reset();
    m1_done = 1'b0;
    fork
      begin
        burst(1, 4, 1'b1, 32'h0000_0100, 32'h0000_00A0);
        m1_done = 1'b1;
      end
      begin
        @(posedge clk); #1;
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0030, '0);
        @(negedge clk);
        checks++; if (grant_o !== 2'b10 || s_we_o !== 1'b1 || s_adr_o !== 32'h100) begin
          $display("FAIL t4_m1_owner: got grant %b we %b adr %h expected 10 1 00000100", grant_o, s_we_o, s_adr_o); errors++;
        end
        wait_ack(0, 200, ok);
        checks++; if (!ok) begin $display("FAIL t4_m0_ack: got no ack expected ack"); errors++; end
        checks++; if (!m1_done) begin $display("FAIL t4_stall: got m0 ack during m1 burst expected none"); errors++; end
        @(posedge clk); #1;
        drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
      end
    join
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[64 + i] !== 32'h0000_00A0 + 32'(i)) begin
        $display("FAIL t4_mem[%0d]: got %h expected %h", i, mem[64 + i], 32'h0000_00A0 + 32'(i)); errors++;
      end
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0050, '0);
    repeat (2) @(negedge clk);
    checks++; if (grant_o !== 2'b01) begin $display("FAIL t5_pre_grant: got %b expected 01", grant_o); errors++; end
    #1 rst = 1'b1;
    #1;
    checks++; if (grant_o !== 2'b00) begin $display("FAIL t5_async_grant: got %b expected 00", grant_o); errors++; end
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin $display("FAIL t5_async_cyc: got %b%b expected 00", s_cyc_o, s_stb_o); errors++; end
    #1 rst = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0060, '0);
    @(negedge clk);
    checks++; if (grant_o !== 2'b10) begin $display("FAIL t5_rearb: got %b expected 10", grant_o); errors++; end
    wait_ack(1, 20, ok);
    checks++; if (!ok) begin $display("FAIL t5_m1_ack: got no ack expected ack"); errors++; end
    @(posedge clk); #1;
    drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    sl_noack = 1'b1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0070, '0);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0074, '0);
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (m0_err_o !== (k == 8) || m1_err_o !== 1'b0) begin
        $display("FAIL t6_err cycle %0d: got m0 %b m1 %b expected %0d 0", k, m0_err_o, m1_err_o, (k == 8)); errors++;
      end
    end
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    sl_noack = 1'b0;
    @(negedge clk);
    checks++; if (grant_o !== 2'b00 || m0_err_o !== 1'b0) begin $display("FAIL t6_idle: got grant %b err %b expected 00 0", grant_o, m0_err_o); errors++; end
    @(negedge clk);
    checks++; if (grant_o !== 2'b10) begin $display("FAIL t6_m1_next: got %b expected 10", grant_o); errors++; end
    do_reset();
  endtask
`else
  task automatic test_err_tied;
    int seen;
    do_reset();
    sl_noack = 1'b1;
    seen = 0;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0070, '0);
    repeat (80) begin
      @(negedge clk);
      if (m0_err_o || m1_err_o) seen++;
    end
    checks++; if (seen != 0) begin $display("FAIL err_tied: got %0d err cycles expected 0", seen); errors++; end
    checks++; if (grant_o !== 2'b01) begin $display("FAIL err_tied_hold: got %b expected 01", grant_o); errors++; end
    do_reset();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_fairness();
    test_burst_hold();
    test_async_reset();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_err_tied();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
